// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: 3-stage approximate unsigned multiplier built from four
// half-width quadrant products, combined per beat by exact add or bitwise OR.
module approx_mult_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned TRUNC = 2,
   parameter logic [3:0]  QMASK = 4'b1100,
   parameter int unsigned CNTW  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [1:0]         in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_r,
   output logic [1:0]         out_mode,
   output logic [CNTW-1:0]    op_count
);
   localparam int unsigned HALF = WIDTH / 2;
   localparam int unsigned PW   = 2 * HALF;
   localparam int unsigned OW   = 2 * WIDTH;
   localparam logic [PW-1:0] TMASK = {PW{1'b1}} << TRUNC;

   logic             w_adv;
   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [1:0]       r_s1_mode;
   logic [PW-1:0]    w_p [4];
   logic [PW-1:0]    w_q [4];
   logic             r_s2_valid;
   logic [PW-1:0]    r_s2_q [4];
   logic [1:0]       r_s2_mode;
   logic [OW-1:0]    w_t0, w_t1, w_t2, w_t3;
   logic [OW-1:0]    w_comb;

   assign w_adv = !out_valid || out_ready;

   // Input ready: whole pipe advances together, held low while in reset
   always_comb begin
      in_ready = 1'b0;
      if (!rst_n) begin
         in_ready = 1'b0;
      end else begin
         in_ready = w_adv;
      end
   end

   // Stage 1: capture operands and mode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_mode  <= 2'b00;
      end else if (w_adv) begin
         r_s1_valid <= in_valid;
         r_s1_a     <= in_a;
         r_s1_b     <= in_b;
         r_s1_mode  <= in_mode;
      end
   end

   // Quadrant products with optional LSB truncation of masked quadrants
   always_comb begin
      w_p[0] = PW'(r_s1_a[HALF-1:0])    * PW'(r_s1_b[HALF-1:0]);
      w_p[1] = PW'(r_s1_a[HALF-1:0])    * PW'(r_s1_b[WIDTH-1:HALF]);
      w_p[2] = PW'(r_s1_a[WIDTH-1:HALF]) * PW'(r_s1_b[HALF-1:0]);
      w_p[3] = PW'(r_s1_a[WIDTH-1:HALF]) * PW'(r_s1_b[WIDTH-1:HALF]);
      for (int i = 0; i < 4; i++) begin
         if (r_s1_mode[1] && QMASK[i]) begin
            w_q[i] = w_p[i] & TMASK;
         end else begin
            w_q[i] = w_p[i];
         end
      end
   end

   // Stage 2: register quadrant products
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_mode  <= 2'b00;
         for (int i = 0; i < 4; i++) r_s2_q[i] <= '0;
      end else if (w_adv) begin
         r_s2_valid <= r_s1_valid;
         r_s2_mode  <= r_s1_mode;
         for (int i = 0; i < 4; i++) r_s2_q[i] <= w_q[i];
      end
   end

   // Combine aligned quadrant terms by sum or OR
   always_comb begin
      w_t0 = OW'(r_s2_q[0]);
      w_t1 = OW'(r_s2_q[1]) << HALF;
      w_t2 = OW'(r_s2_q[2]) << HALF;
      w_t3 = OW'(r_s2_q[3]) << WIDTH;
      if (r_s2_mode[0]) begin
         w_comb = w_t0 | w_t1 | w_t2 | w_t3;
      end else begin
         w_comb = w_t0 + w_t1 + w_t2 + w_t3;
      end
   end

   // Stage 3: registered outputs, held while downstream stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_r     <= '0;
         out_mode  <= 2'b00;
      end else if (w_adv) begin
         out_valid <= r_s2_valid;
         out_r     <= w_comb;
         out_mode  <= r_s2_mode;
      end
   end

   // Completed-handshake counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (out_valid && out_ready) begin
         op_count <= op_count + CNTW'(1);
      end
   end
endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe: constant vector table, stall/reset sequences and
// a randomized stream checked against an arithmetic quadrant model.
module tb_approx_mult_pipe;
   localparam logic [3:0] QMASK_TB = 4'b1100;

   logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [7:0]  in_a, in_b;
   logic [1:0]  in_mode, out_mode;
   logic [15:0] out_r, op_count;

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;
   int cnt_model = 0;
   bit hold_pend = 1'b0;
   logic [15:0] held_r;
   logic [1:0]  held_mode;
   logic [17:0] exp_q [$];

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [1:0]  mode;
      logic [15:0] exp_r;
   } vec_t;
   vec_t vecs [8];

   approx_mult_pipe #(.WIDTH(8), .TRUNC(2), .QMASK(4'b1100), .CNTW(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_r(out_r), .out_mode(out_mode), .op_count(op_count));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Quadrant reference from plain integer arithmetic on nibbles
   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] m);
      int q [4];
      int al = int'(a) % 16, ah = int'(a) / 16, bl = int'(b) % 16, bh = int'(b) / 16;
      q[0] = al * bl; q[1] = al * bh; q[2] = ah * bl; q[3] = ah * bh;
      for (int i = 0; i < 4; i++)
         if (m[1] && QMASK_TB[i]) q[i] = (q[i] / 4) * 4;
      if (!m[0]) return 16'(q[0] + (q[1] + q[2]) * 16 + q[3] * 256);
      return 16'(q[0]) | 16'(q[1] * 16) | 16'(q[2] * 16) | 16'(q[3] * 256);
   endfunction

   // Scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      logic [17:0] e;
      if (mon_en && rst_n) begin
         chk("in_ready_rule", in_ready, !out_valid || out_ready);
         chk("op_count", op_count, cnt_model[15:0]);
         if (hold_pend) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_r", out_r, held_r);
            chk("hold_mode", out_mode, held_mode);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("stream_r", out_r, e[15:0]);
               chk("stream_mode", out_mode, e[17:16]);
            end
            cnt_model++;
         end
         if (in_valid && in_ready) exp_q.push_back({in_mode, model(in_a, in_b, in_mode)});
         hold_pend = out_valid && !out_ready;
         held_r    = out_r;
         held_mode = out_mode;
      end
   end

   function automatic logic [7:0] pick();
      case ($urandom_range(0, 7))
         0: return 8'h00;
         1: return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic new_beat();
      in_a = pick(); in_b = pick(); in_mode = 2'($urandom_range(0, 3));
   endtask

   task automatic stream(input int n, input int st, input int sl, input bit rnd);
      int sent = 0;
      int cyc = 0;
      bit acc;
      new_beat();
      in_valid = 1'b1;
      while (sent < n && cyc < n * 8 + 50) begin
         if (cyc >= st && cyc < st + sl) out_ready = 1'b0;
         else if (rnd) out_ready = ($urandom_range(0, 3) != 0);
         else out_ready = 1'b1;
         @(negedge clk);
         acc = in_valid && in_ready;
         if (cyc >= st && cyc < st + sl && out_valid) chk("stall_in_ready", in_ready, 1'b0);
         @(posedge clk); #1;
         if (acc) begin
            sent++;
            new_beat();
            in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         end else if (!in_valid) begin
            in_valid = ($urandom_range(0, 1) == 1);
         end
         cyc++;
      end
      in_valid = 1'b0;
      chk("stream_sent", sent, n);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #2;
         if (exp_q.size() == 0 && !out_valid) break;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      vecs[0] = '{8'hFF, 8'hFF, 2'b00, 16'hFE01};
      vecs[1] = '{8'h11, 8'h11, 2'b01, 16'h0111};
      vecs[2] = '{8'hFF, 8'hFF, 2'b10, 16'hFCF1};
      vecs[3] = '{8'hFF, 8'hFF, 2'b11, 16'hEEF1};
      vecs[4] = '{8'h00, 8'hFF, 2'b00, 16'h0000};
      vecs[5] = '{8'hA5, 8'h3C, 2'b00, 16'h26AC};
      vecs[6] = '{8'h11, 8'h11, 2'b10, 16'h0011};
      vecs[7] = '{8'h80, 8'h02, 2'b00, 16'h0100};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_a = 8'h00; in_b = 8'h00; in_mode = 2'b00;
      #7;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_r", out_r, 16'h0000);
      chk("rst_op_count", op_count, 16'h0000);
      chk("rst_in_ready", in_ready, 1'b0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         in_a = vecs[i].a; in_b = vecs[i].b; in_mode = vecs[i].mode; in_valid = 1'b1;
         #1 chk("vec_in_ready", in_ready, 1'b1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(posedge clk); #1;
         chk("vec_early_valid", out_valid, 1'b0);
         @(posedge clk); #1;
         chk("vec_valid", out_valid, 1'b1);
         chk("vec_r", out_r, vecs[i].exp_r);
         chk("vec_mode", out_mode, vecs[i].mode);
         @(posedge clk); #1;
         chk("vec_count", op_count, i + 1);
      end

      // Three beats in flight, then asynchronous reset mid-cycle
      for (int i = 0; i < 3; i++) begin
         new_beat(); in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_r", out_r, 16'h0000);
      chk("mid_rst_mode", out_mode, 2'b00);
      chk("mid_rst_count", op_count, 16'h0000);
      chk("mid_rst_ready", in_ready, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_rst_no_stale", out_valid, 1'b0);
      end
      exp_q.delete();
      cnt_model = 0;
      hold_pend = 1'b0;
      mon_en = 1'b1;
      @(posedge clk); #1;

      stream(10, 4, 4, 1'b0);
      drain();
      chk("stall_count", op_count, 16'd10);

      stream(10000, -1, 0, 1'b1);
      drain();
      chk("rand_count", op_count, cnt_model[15:0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
